// File: rtl/laser_search_ctrl.sv
// ---------------------------------------------------------------------------
// laser_search_ctrl
//
// Two-circle laser coverage search on a 16x16 grid. A round loads NUM_PTS
// target points, then alternately re-optimises circle 1 (SCAN_A) and
// circle 2 (SCAN_B). Each scan tries all 256 candidate centres, one per
// cycle, and scores every candidate against all points in that cycle. The
// search stops when a full C1+C2 pass stops improving or the pass cap is
// hit. The best pair is then reported with a one-cycle DONE pulse.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   X, Y       point coordinates, sampled once per cycle while loading
//   C1X, C1Y   reported centre of circle 1 (held until next DONE/reset)
//   C2X, C2Y   reported centre of circle 2 (held until next DONE/reset)
//   COVER_CNT  points covered by the union of the reported circles
//   DONE       one-cycle pulse, outputs above are valid in that cycle
// ---------------------------------------------------------------------------
module laser_search_ctrl #(
    parameter int NUM_PTS    = 40,
    parameter int MAX_PASSES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] COVER_CNT,
    output logic       DONE
);

    localparam int PW = $clog2(MAX_PASSES + 1);

    typedef enum logic [1:0] {LOAD, SCAN_A, SCAN_B, REPORT} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [3:0]    pt_x [NUM_PTS];
    logic [3:0]    pt_y [NUM_PTS];
    logic [5:0]    load_idx;

    // Centres are kept as packed grid indices: [3:0] = x, [7:4] = y.
    logic [7:0]    cand_idx;
    logic [7:0]    best_idx;
    logic [7:0]    best_idx_nxt;
    logic [7:0]    w1;
    logic [7:0]    w2;
    logic [7:0]    fixed_c;

    logic [5:0]    score;
    logic [5:0]    best_score;
    logic [5:0]    best_score_nxt;
    logic [5:0]    last_total;

    logic [PW-1:0] pass_cnt;
    logic [PW-1:0] pass_nxt;
    logic          scan_last;
    logic          stop;

    // Radius-4 coverage lookup: one row per |dx|, bit dy set when covered.
    function automatic logic covers(input logic [7:0] c,
                                    input logic [3:0] px,
                                    input logic [3:0] py);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] row;
        dx = (c[3:0] >= px) ? (c[3:0] - px) : (px - c[3:0]);
        dy = (c[7:4] >= py) ? (c[7:4] - py) : (py - c[7:4]);
        case (dx)
            4'd0:    row = 8'b0001_1111;
            4'd1:    row = 8'b0000_1111;
            4'd2:    row = 8'b0000_1111;
            4'd3:    row = 8'b0000_0111;
            4'd4:    row = 8'b0000_0001;
            default: row = 8'b0000_0000;
        endcase
        return (dy <= 4'd4) && row[dy[2:0]];
    endfunction

    // Score the current candidate against the circle that is held fixed in
    // this scan, and track the running best. Only a strictly greater score
    // replaces the best, so the lowest candidate index wins ties.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        score   = '0;
        fixed_c = (state == SCAN_B) ? w1 : w2;
        for (int i = 0; i < NUM_PTS; i++) begin
            hit   = covers(cand_idx, pt_x[i], pt_y[i]) |
                    covers(fixed_c, pt_x[i], pt_y[i]);
            score = score + {5'd0, hit};
        end
        best_idx_nxt   = best_idx;
        best_score_nxt = best_score;
        if (score > best_score) begin
            best_idx_nxt   = cand_idx;
            best_score_nxt = score;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and DONE. After a C2 scan the round ends if the pass total
    // did not improve on the previous pass, or the pass cap has been hit.
    always_comb begin
        state_nxt = state;
        DONE      = 1'b0;
        scan_last = (cand_idx == 8'hFF);
        pass_nxt  = pass_cnt + PW'(1);
        stop      = (best_score_nxt <= last_total) ||
                    (pass_nxt >= PW'(MAX_PASSES));
        case (state)
            LOAD: begin
                if (load_idx == 6'(NUM_PTS - 1)) begin
                    state_nxt = SCAN_A;
                end
            end
            SCAN_A: begin
                if (scan_last) begin
                    state_nxt = SCAN_B;
                end
            end
            SCAN_B: begin
                if (scan_last) begin
                    state_nxt = stop ? REPORT : SCAN_A;
                end
            end
            REPORT: begin
                DONE      = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath: point store, scan bookkeeping and reported results. The
    // outputs are loaded on the edge that enters REPORT so they are valid
    // while DONE is high, and then simply hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_PTS; i++) begin
                pt_x[i] <= '0;
                pt_y[i] <= '0;
            end
            load_idx   <= '0;
            cand_idx   <= '0;
            best_idx   <= '0;
            best_score <= '0;
            w1         <= '0;
            w2         <= '0;
            last_total <= '0;
            pass_cnt   <= '0;
            C1X        <= '0;
            C1Y        <= '0;
            C2X        <= '0;
            C2Y        <= '0;
            COVER_CNT  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    pt_x[load_idx] <= X;
                    pt_y[load_idx] <= Y;
                    load_idx   <= (load_idx == 6'(NUM_PTS - 1)) ? 6'd0 : load_idx + 6'd1;
                    cand_idx   <= '0;
                    best_idx   <= '0;
                    best_score <= '0;
                    w1         <= '0;
                    w2         <= '0;
                    last_total <= '0;
                    pass_cnt   <= '0;
                end
                SCAN_A, SCAN_B: begin
                    cand_idx <= cand_idx + 8'd1;
                    if (scan_last) begin
                        best_idx   <= '0;
                        best_score <= '0;
                        pass_cnt   <= pass_nxt;
                        if (state == SCAN_A) begin
                            w1 <= best_idx_nxt;
                        end else begin
                            w2 <= best_idx_nxt;
                            if (stop) begin
                                C1X       <= w1[3:0];
                                C1Y       <= w1[7:4];
                                C2X       <= best_idx_nxt[3:0];
                                C2Y       <= best_idx_nxt[7:4];
                                COVER_CNT <= best_score_nxt;
                            end else begin
                                last_total <= best_score_nxt;
                            end
                        end
                    end else begin
                        best_idx   <= best_idx_nxt;
                        best_score <= best_score_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_laser_search_ctrl
//
// Drives fixed and randomised 40-point rounds into laser_search_ctrl and
// compares every cycle against a behavioural model of the two-circle
// search. A second instance with MAX_PASSES=2 exercises the pass cap.
// ---------------------------------------------------------------------------
module tb_laser_search_ctrl;

    localparam int LIMIT = 40 + 260 * 8 + 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic [3:0] x;
    logic [3:0] y;

    logic [3:0] c1x, c1y, c2x, c2y;
    logic [5:0] cnt;
    logic       done;
    logic [3:0] c1x_2, c1y_2, c2x_2, c2y_2;
    logic [5:0] cnt_2;
    logic       done_2;

    logic [21:0] out_v  [2];
    logic        done_v [2];
    logic        rst_v  [2];

    int          checks = 0;
    int          errors = 0;

    int          pt_x [40];
    int          pt_y [40];

    logic        pend_valid [2];
    logic [21:0] pend_exp   [2];
    logic [21:0] held_exp   [2];
    int          exp_passes [2];

    always #5 clk = ~clk;

    assign out_v[0]  = {c1x, c1y, c2x, c2y, cnt};
    assign out_v[1]  = {c1x_2, c1y_2, c2x_2, c2y_2, cnt_2};
    assign done_v[0] = done;
    assign done_v[1] = done_2;
    assign rst_v[0]  = rst_n;
    assign rst_v[1]  = rst2_n;

    laser_search_ctrl dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .X         (x),
        .Y         (y),
        .C1X       (c1x),
        .C1Y       (c1y),
        .C2X       (c2x),
        .C2Y       (c2y),
        .COVER_CNT (cnt),
        .DONE      (done)
    );

    laser_search_ctrl #(.MAX_PASSES(2)) dut2 (
        .CLK       (clk),
        .RST_N     (rst2_n),
        .X         (x),
        .Y         (y),
        .C1X       (c1x_2),
        .C1Y       (c1y_2),
        .C2X       (c2x_2),
        .C2Y       (c2y_2),
        .COVER_CNT (cnt_2),
        .DONE      (done_2)
    );

    function automatic logic [21:0] pack(input int ax, input int ay,
                                         input int bx, input int by,
                                         input int c);
        return {ax[3:0], ay[3:0], bx[3:0], by[3:0], c[5:0]};
    endfunction

    // Radius-4 reach: how far dy may go for each |dx|.
    function automatic bit coveredBy(input int cx, input int cy,
                                     input int px, input int py);
        int dx, dy, reach;
        dx = (cx > px) ? cx - px : px - cx;
        dy = (cy > py) ? cy - py : py - cy;
        if (dx > 4) return 1'b0;
        reach = (dx == 0) ? 4 : (dx <= 2) ? 3 : (dx == 3) ? 2 : 0;
        return dy <= reach;
    endfunction

    // Whole-round search result for the points currently in pt_x/pt_y.
    task automatic modelRound(input int max_passes, output logic [21:0] result,
                              output int passes);
        int w1, w2, last, best, best_score, score, other;
        bit fin;
        w1 = 0; w2 = 0; last = 0; passes = 0; fin = 1'b0; best_score = 0;
        while (!fin) begin
            for (int side = 0; side < 2; side++) begin
                other      = (side == 0) ? w2 : w1;
                best       = 0;
                best_score = 0;
                for (int cand = 0; cand < 256; cand++) begin
                    score = 0;
                    for (int p = 0; p < 40; p++) begin
                        if (coveredBy(cand % 16, cand / 16, pt_x[p], pt_y[p]) ||
                            coveredBy(other % 16, other / 16, pt_x[p], pt_y[p]))
                            score++;
                    end
                    if (score > best_score) begin
                        best_score = score;
                        best       = cand;
                    end
                end
                if (side == 0) w1 = best;
                else           w2 = best;
                passes++;
            end
            if (best_score <= last || passes >= max_passes) fin = 1'b1;
            else last = best_score;
        end
        result = pack(w1 % 16, w1 / 16, w2 % 16, w2 / 16, best_score);
    endtask

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s dut%0d got %h expected %h", name, k, got, expv);
        end
    endtask

    task automatic checkLatency(input int k, input int n);
        int lo, hi;
        lo = 40 + 256 * exp_passes[k];
        hi = 40 + 260 * exp_passes[k] + 2;
        checks++;
        if (n < lo || n > hi) begin
            errors++;
            $display("[TB] FAIL done_latency dut%0d got %0d cycles required %0d..%0d",
                     k, n, lo, hi);
        end
    endtask

    task automatic setScenario(input int s);
        int nc, c, v;
        int cxs [4];
        int cys [4];
        nc = int'($urandom_range(4, 1));
        for (int j = 0; j < 4; j++) begin
            cxs[j] = int'($urandom_range(15, 0));
            cys[j] = int'($urandom_range(15, 0));
        end
        for (int i = 0; i < 40; i++) begin
            case (s)
                1: begin pt_x[i] = 5; pt_y[i] = 5; end
                2: begin pt_x[i] = (i < 20) ? 2 : 13; pt_y[i] = pt_x[i]; end
                3: begin
                    pt_x[i] = ((i / 10) % 2 == 1) ? 15 : 0;
                    pt_y[i] = (i >= 20) ? 15 : 0;
                end
                default: begin
                    c = int'($urandom_range(nc - 1, 0));
                    v = cxs[c] + int'($urandom_range(6, 0)) - 3;
                    pt_x[i] = (v < 0) ? 0 : (v > 15) ? 15 : v;
                    v = cys[c] + int'($urandom_range(6, 0)) - 3;
                    pt_y[i] = (v < 0) ? 0 : (v > 15) ? 15 : v;
                end
            endcase
        end
    endtask

    // Called at a falling edge whose following rising edge samples point 0.
    task automatic applyStimulus(input bit both);
        logic [21:0] r;
        int          p;
        modelRound(8, r, p);
        pend_exp[0] = r; exp_passes[0] = p; pend_valid[0] = 1'b1;
        if (both) begin
            modelRound(2, r, p);
            pend_exp[1] = r; exp_passes[1] = p; pend_valid[1] = 1'b1;
        end
        x = 4'(pt_x[0]);
        y = 4'(pt_y[0]);
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            x = 4'(pt_x[i]);
            y = 4'(pt_y[i]);
        end
    endtask

    task automatic waitDone(input int k, input int n0, output int n);
        bit seen;
        seen = 1'b0;
        n    = n0;
        while (!seen && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (done_v[k]) seen = 1'b1;
            else begin
                x = 4'($urandom);
                y = 4'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout dut%0d waited %0d cycles limit %0d", k, n, LIMIT);
        end
    endtask

    // Cycle-by-cycle compare: zero in reset, expected result on DONE,
    // previous result held otherwise.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_v[k]) begin
                held_exp[k] = '0;
                checkOutput("reset_state", k, 32'({done_v[k], out_v[k]}), 32'd0);
            end else if (done_v[k]) begin
                checkOutput("done_has_round", k, 32'(pend_valid[k]), 32'd1);
                if (pend_valid[k]) begin
                    checkOutput("done_outputs", k, 32'(out_v[k]), 32'(pend_exp[k]));
                    held_exp[k]   = pend_exp[k];
                    pend_valid[k] = 1'b0;
                end
            end else begin
                checkOutput("hold_outputs", k, 32'(out_v[k]), 32'(held_exp[k]));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, n2;
        rst_n = 1'b0; rst2_n = 1'b0; x = '0; y = '0;
        pend_valid[0] = 1'b0; pend_valid[1] = 1'b0;
        held_exp[0] = '0; held_exp[1] = '0;
        repeat (3) @(negedge clk);
        checkOutput("lit_reset", 0, 32'({done, out_v[0]}), 32'd0);

        // Round 1: all points stacked at (5,5).
        $display("[TB] scenario 1");
        setScenario(1);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        checkOutput("model_pin_s1", 0, 32'(pend_exp[0]), 32'(pack(5, 1, 0, 0, 40)));
        checkOutput("model_pin_passes", 0, 32'(exp_passes[0]), 32'd4);
        waitDone(0, 39, n);
        checkLatency(0, n);
        checkOutput("lit_s1", 0, 32'(out_v[0]), 32'(pack(5, 1, 0, 0, 40)));

        // Back to back: four corners, ties go to the lowest index.
        $display("[TB] scenario 3");
        @(negedge clk);
        setScenario(3);
        applyStimulus(1'b0);
        waitDone(0, 39, n);
        checkLatency(0, n);
        checkOutput("lit_s3", 0, 32'(out_v[0]), 32'(pack(11, 0, 0, 0, 20)));

        // Back to back: two clusters.
        $display("[TB] scenario 2");
        @(negedge clk);
        setScenario(2);
        applyStimulus(1'b0);
        waitDone(0, 39, n);
        checkLatency(0, n);
        checkOutput("lit_s2", 0, 32'(out_v[0]), 32'(pack(13, 9, 0, 0, 40)));

        // Reset during the first C2 scan abandons the round.
        $display("[TB] reset mid scan");
        @(negedge clk);
        setScenario(1);
        applyStimulus(1'b0);
        repeat (256 + 100) @(negedge clk);
        #2 rst_n = 1'b0;
        pend_valid[0] = 1'b0;
        #1 checkOutput("async_reset", 0, 32'({done, out_v[0]}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        waitDone(0, 39, n);
        checkLatency(0, n);
        checkOutput("lit_s1_after_reset", 0, 32'(out_v[0]), 32'(pack(5, 1, 0, 0, 40)));

        // Randomised clustered rounds, back to back.
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random round %0d", r);
            @(negedge clk);
            setScenario(4);
            applyStimulus(1'b0);
            waitDone(0, 39, n);
            checkLatency(0, n);
        end

        // Pass cap: both instances see the two-cluster round.
        $display("[TB] pass cap");
        @(negedge clk);
        #2 rst_n = 1'b0;
        pend_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        setScenario(2);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        applyStimulus(1'b1);
        checkOutput("model_pin_cap_passes", 1, 32'(exp_passes[1]), 32'd2);
        waitDone(1, 39, n2);
        checkLatency(1, n2);
        checkOutput("lit_cap", 1, 32'(out_v[1]), 32'(pack(13, 9, 0, 0, 40)));
        #2 rst2_n = 1'b0;
        pend_valid[1] = 1'b0;
        waitDone(0, n2, n);
        checkLatency(0, n);
        checkOutput("lit_nocap", 0, 32'(out_v[0]), 32'(pack(13, 9, 0, 0, 40)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
